write_back: RTL and testbench

- Final pipeline stage. Sits directly downstream of the memory-access stage and consumes its registered `*_next` outputs.
- Selects the write-back value (ALU result, load data, link address or a UART receive byte) and drives one registered write port shared by the integer and float register files. The same port doubles as the forwarding source.
- Owns the only multi-cycle wait in the pipe: a UART-read instruction blocks here until a byte arrives, and the stage back-pressures upstream with `stall`.

---
 rtl/write_back_if.sv | 34 +++
 rtl/write_back.sv | 111 +++++++++++
 tb/tb_write_back.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_back_if.sv
// Memory-access to write-back token bus plus the UART RX handshake.
// The stage drives stall/uart_ready back to its producers.
interface write_back_if #(
  parameter int INST_MEM_WIDTH = 2
);
  logic                      distinct;
  logic                      AorF;
  logic                      RegWrite;
  logic [1:0]                MemtoReg;
  logic                      UARTtoReg;
  logic [31:0]               read_data;
  logic [31:0]               alu_result;
  logic [4:0]                rdist;
  logic [INST_MEM_WIDTH-1:0] pc;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic [7:0]                uart_data;
  logic                      uart_valid;
  logic                      uart_ready;
  logic                      stall;

  modport master (
    output distinct, AorF, RegWrite, MemtoReg, UARTtoReg,
    output read_data, alu_result, rdist, pc, pc1,
    output uart_data, uart_valid,
    input  uart_ready, stall
  );

  modport slave (
    input  distinct, AorF, RegWrite, MemtoReg, UARTtoReg,
    input  read_data, alu_result, rdist, pc, pc1,
    input  uart_data, uart_valid,
    output uart_ready, stall
  );
endinterface

// File: rtl/write_back.sv
// Write-back stage: shared int/float write port, UART-read wait state.
// Optional WB_RETIRE_COUNT_EN adds a free-running retire_count output.
module write_back #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  write_back_if.slave               mem,
  output logic                      wb_we_int,
  output logic                      wb_we_float,
  output logic [4:0]                wb_addr,
  output logic [31:0]               wb_data,
  output logic                      retired,
  output logic [INST_MEM_WIDTH-1:0] retired_pc
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]               retire_count
`endif
);

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_UART = 1'b1
  } state_t;

  state_t                    state;
  logic                      cap_af;
  logic                      cap_rw;
  logic [4:0]                cap_rd;
  logic [INST_MEM_WIDTH-1:0] cap_pc;
  logic [31:0]               src;

  assign mem.stall      = (state == WAIT_UART);
  assign mem.uart_ready = (state == WAIT_UART);

  always_comb begin
    src = mem.alu_result;
    unique case (mem.MemtoReg)
      2'b01:   src = mem.read_data;
      2'b10:   src = 32'(mem.pc1);
      default: src = mem.alu_result;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cap_af      <= 1'b0;
      cap_rw      <= 1'b0;
      cap_rd      <= '0;
      cap_pc      <= '0;
      wb_we_int   <= 1'b0;
      wb_we_float <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      retired     <= 1'b0;
      retired_pc  <= '0;
    end else begin
      wb_we_int   <= 1'b0;
      wb_we_float <= 1'b0;
      retired     <= 1'b0;
      unique case (state)
        RUN: begin
          if (mem.distinct) begin
            if (mem.UARTtoReg) begin
              cap_af <= mem.AorF;
              cap_rw <= mem.RegWrite;
              cap_rd <= mem.rdist;
              cap_pc <= mem.pc;
              state  <= WAIT_UART;
            end else begin
              wb_we_int   <= mem.RegWrite & ~mem.AorF
                             & (mem.rdist != 5'd0);
              wb_we_float <= mem.RegWrite & mem.AorF;
              wb_addr     <= mem.rdist;
              wb_data     <= src;
              retired     <= 1'b1;
              retired_pc  <= mem.pc;
            end
          end
        end
        WAIT_UART: begin
          if (mem.uart_valid) begin
            wb_we_int   <= cap_rw & ~cap_af & (cap_rd != 5'd0);
            wb_we_float <= cap_rw & cap_af;
            wb_addr     <= cap_rd;
            wb_data     <= {24'b0, mem.uart_data};
            retired     <= 1'b1;
            retired_pc  <= cap_pc;
            state       <= RUN;
          end
        end
      endcase
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic retire_d;

  assign retire_d = ((state == RUN) & mem.distinct & ~mem.UARTtoReg)
                  | ((state == WAIT_UART) & mem.uart_valid);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      retire_count <= '0;
    else if (retire_d)
      retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed plan cases plus
// randomized tokens checked against a pending-read reference model.
module tb_write_back;
  localparam int W = 2;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          wb_we_int;
  logic          wb_we_float;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          retired;
  logic [W-1:0]  retired_pc;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0]   retire_count;
`endif

  int tests = 0;
  int fails = 0;

  write_back_if #(.INST_MEM_WIDTH(W)) bus();

  write_back #(.INST_MEM_WIDTH(W)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .mem         (bus),
    .wb_we_int   (wb_we_int),
    .wb_we_float (wb_we_float),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .retired     (retired),
    .retired_pc  (retired_pc)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count(retire_count)
`endif
  );

  always #5 CLK = ~CLK;

  // reference model: a UART read is either pending (with its fields) or not
  bit          m_pend;
  logic        m_af, m_rw;
  logic [4:0]  m_rd;
  logic [W-1:0] m_pc;
  logic        e_wi, e_wf, e_ret;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [W-1:0] e_rpc;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic tok(input logic d, input logic u, input logic af,
                     input logic rw, input logic [1:0] mr,
                     input logic [4:0] rd, input logic [31:0] alu,
                     input logic [31:0] rdat, input logic [W-1:0] p,
                     input logic [W-1:0] p1);
    bus.distinct   = d;
    bus.UARTtoReg  = u;
    bus.AorF       = af;
    bus.RegWrite   = rw;
    bus.MemtoReg   = mr;
    bus.rdist      = rd;
    bus.alu_result = alu;
    bus.read_data  = rdat;
    bus.pc         = p;
    bus.pc1        = p1;
  endtask

  task automatic idle();
    tok(0, 0, 0, 0, 2'b00, 5'd0, 32'd0, 32'd0, '0, '0);
  endtask

  task automatic model_write(input logic af, input logic rw,
                             input logic [4:0] rd, input logic [31:0] v,
                             input logic [W-1:0] p);
    e_wi   = rw && !af && rd != 0;
    e_wf   = rw && af;
    e_addr = rd;
    e_data = v;
    e_ret  = 1'b1;
    e_rpc  = p;
  endtask

  task automatic model_edge();
    logic [31:0] v;
    e_wi  = 1'b0;
    e_wf  = 1'b0;
    e_ret = 1'b0;
    if (!m_pend) begin
      if (bus.distinct && bus.UARTtoReg) begin
        m_pend = 1'b1;
        m_af   = bus.AorF;
        m_rw   = bus.RegWrite;
        m_rd   = bus.rdist;
        m_pc   = bus.pc;
      end else if (bus.distinct) begin
        if (bus.MemtoReg == 2'd1)      v = bus.read_data;
        else if (bus.MemtoReg == 2'd2) v = 32'(bus.pc1);
        else                           v = bus.alu_result;
        model_write(bus.AorF, bus.RegWrite, bus.rdist, v, bus.pc);
      end
    end else if (bus.uart_valid) begin
      model_write(m_af, m_rw, m_rd, {24'b0, bus.uart_data}, m_pc);
      m_pend = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle();
    bus.uart_valid = 1'b0;
    bus.uart_data  = 8'h00;
    reset = 1'b0;
    step();
    tests++;
    if ({bus.stall, bus.uart_ready, wb_we_int, wb_we_float, wb_addr,
         wb_data, retired, retired_pc} !== 44'd0) begin
      fails++;
      $display("FAIL reset_state got %h want 0",
               {bus.stall, bus.uart_ready, wb_we_int, wb_we_float,
                wb_addr, wb_data, retired, retired_pc});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu();
    tok(1, 0, 0, 1, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 2'd1, 2'd2);
    step();
    tests++;
    if ({wb_we_int, wb_we_float, wb_addr, wb_data, retired, retired_pc}
        !== {1'b1, 1'b0, 5'd5, 32'h1234, 1'b1, 2'd1}) begin
      fails++;
      $display("FAIL alu_write got %b %b %0d %h %b want 1 0 5 1234 1",
               wb_we_int, wb_we_float, wb_addr, wb_data, retired);
    end
    idle();
    step();
    tests++;
    if ({wb_we_int, retired, wb_addr, wb_data}
        !== {1'b0, 1'b0, 5'd5, 32'h1234}) begin
      fails++;
      $display("FAIL alu_pulse got we=%b ret=%b addr=%0d data=%h",
               wb_we_int, retired, wb_addr, wb_data);
    end
  endtask

  task automatic test_load_r0();
    tok(1, 0, 0, 1, 2'b01, 5'd0, 32'h1, 32'hDEAD_BEEF, 2'd2, 2'd3);
    step();
    tests++;
    if ({wb_we_int, wb_we_float, retired} !== 3'b001) begin
      fails++;
      $display("FAIL load_r0 got wi=%b wf=%b ret=%b want 0 0 1",
               wb_we_int, wb_we_float, retired);
    end
    tok(1, 0, 1, 1, 2'b01, 5'd0, 32'h1, 32'hDEAD_BEEF, 2'd2, 2'd3);
    step();
    tests++;
    if ({wb_we_int, wb_we_float, wb_addr, wb_data}
        !== {1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL load_f0 got wi=%b wf=%b addr=%0d data=%h",
               wb_we_int, wb_we_float, wb_addr, wb_data);
    end
  endtask

  task automatic test_link();
    tok(1, 0, 0, 1, 2'b10, 5'd31, 32'h77, 32'h88, 2'd2, 2'b11);
    step();
    tests++;
    if ({wb_we_int, wb_addr, wb_data} !== {1'b1, 5'd31, 32'h3}) begin
      fails++;
      $display("FAIL link got we=%b addr=%0d data=%h want 1 31 3",
               wb_we_int, wb_addr, wb_data);
    end
    tok(1, 0, 0, 1, 2'b11, 5'd4, 32'h99, 32'h88, 2'd0, 2'd1);
    step();
    tests++;
    if ({wb_we_int, wb_addr, wb_data} !== {1'b1, 5'd4, 32'h99}) begin
      fails++;
      $display("FAIL sel11 got we=%b addr=%0d data=%h want 1 4 99",
               wb_we_int, wb_addr, wb_data);
    end
  endtask

  task automatic test_uart_wait();
    bus.uart_valid = 1'b0;
    tok(1, 1, 0, 1, 2'b00, 5'd7, 32'h5, 32'h6, 2'd2, 2'd3);
    step();
    tok(1, 0, 0, 1, 2'b00, 5'd9, 32'hAA, 32'h0, 2'd3, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({bus.stall, bus.uart_ready, wb_we_int, wb_we_float, retired}
          !== 5'b11000) begin
        fails++;
        $display("FAIL uart_wait%0d got st=%b rdy=%b wi=%b wf=%b ret=%b",
                 i, bus.stall, bus.uart_ready, wb_we_int, wb_we_float,
                 retired);
      end
      step();
    end
    bus.uart_valid = 1'b1;
    bus.uart_data  = 8'h41;
    step();
    bus.uart_valid = 1'b0;
    tests++;
    if ({wb_we_int, wb_addr, wb_data, retired, retired_pc, bus.stall}
        !== {1'b1, 5'd7, 32'h41, 1'b1, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL uart_byte got we=%b addr=%0d data=%h ret=%b pc=%0d st=%b",
               wb_we_int, wb_addr, wb_data, retired, retired_pc, bus.stall);
    end
    step();
    tests++;
    if ({wb_we_int, wb_addr, wb_data, retired, retired_pc}
        !== {1'b1, 5'd9, 32'hAA, 1'b1, 2'd3}) begin
      fails++;
      $display("FAIL held_tok got we=%b addr=%0d data=%h ret=%b pc=%0d",
               wb_we_int, wb_addr, wb_data, retired, retired_pc);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_wait();
    bus.uart_valid = 1'b0;
    tok(1, 1, 0, 1, 2'b00, 5'd3, 32'h0, 32'h0, 2'd1, 2'd2);
    step();
    idle();
    step();
    bus.uart_valid = 1'b1;
    bus.uart_data  = 8'h55;
    #1 reset = 1'b0;
    #1;
    tests++;
    if ({bus.stall, bus.uart_ready, wb_we_int, retired} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_async got st=%b rdy=%b we=%b ret=%b",
               bus.stall, bus.uart_ready, wb_we_int, retired);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({bus.stall, bus.uart_ready, wb_we_int, wb_we_float, retired}
          !== 5'b00000) begin
        fails++;
        $display("FAIL rst_drop%0d got st=%b rdy=%b wi=%b wf=%b ret=%b",
                 i, bus.stall, bus.uart_ready, wb_we_int, wb_we_float,
                 retired);
      end
    end
    bus.uart_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit was_pend;
    reset = 1'b0;
    idle();
    bus.uart_valid = 1'b0;
    step();
    reset    = 1'b1;
    m_pend   = 1'b0;
    was_pend = 1'b0;
    {e_wi, e_wf, e_ret} = 3'b000;
    e_addr = '0;
    e_data = '0;
    e_rpc  = '0;
    for (int c = 0; c < 400; c++) begin
      tests++;
      if ({bus.stall, bus.uart_ready, wb_we_int, wb_we_float, wb_addr,
           wb_data, retired, retired_pc}
          !== {m_pend, m_pend, e_wi, e_wf, e_addr, e_data, e_ret, e_rpc})
      begin
        fails++;
        $display("FAIL rand%0d got %h want %h", c,
                 {bus.stall, bus.uart_ready, wb_we_int, wb_we_float,
                  wb_addr, wb_data, retired, retired_pc},
                 {m_pend, m_pend, e_wi, e_wf, e_addr, e_data, e_ret,
                  e_rpc});
      end
      if (!was_pend) begin
        r = $urandom;
        bus.distinct   = (r[1:0] != 2'b00);
        bus.UARTtoReg  = (r[4:2] == 3'b000);
        bus.AorF       = r[5];
        bus.RegWrite   = r[6] | r[7];
        bus.MemtoReg   = r[9:8];
        bus.rdist      = (r[11:10] == 2'b00) ? 5'd0 : r[16:12];
        bus.pc         = r[18:17];
        bus.pc1        = r[20:19];
        bus.alu_result = $urandom;
        bus.read_data  = $urandom;
      end
      r = $urandom;
      bus.uart_valid = (r[1:0] == 2'b00);
      bus.uart_data  = r[15:8];
      was_pend = m_pend;
      model_edge();
      step();
    end
    idle();
    bus.uart_valid = 1'b0;
  endtask

`ifdef WB_RETIRE_COUNT_EN
  task automatic test_retire_count();
    reset = 1'b0;
    idle();
    bus.uart_valid = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tok(1, 0, 0, 1, 2'b00, 5'(i + 1), 32'(i), 32'h0, 2'(i), 2'd0);
      step();
    end
    tok(1, 1, 0, 1, 2'b00, 5'd2, 32'h0, 32'h0, 2'd0, 2'd0);
    step();
    idle();
    bus.uart_valid = 1'b1;
    bus.uart_data  = 8'h12;
    step();
    bus.uart_valid = 1'b0;
    step();
    tests++;
    if (retire_count !== 32'd11) begin
      fails++;
      $display("FAIL retire_count got %0d want 11", retire_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load_r0();
    test_link();
    test_uart_wait();
    test_reset_mid_wait();
    test_random();
`ifdef WB_RETIRE_COUNT_EN
    test_retire_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
